axis_sample_feeder: RTL and testbench

- AXI-Stream master that transmits one input vector (one image) into the network's streaming input, i.e. the transmitter end of the layer-1 input stream.
- Samples are preloaded by a simple write port from the control side. A start pulse then streams NUM_SAMPLES words with valid/ready handshake and last on the final word.
- Sits between the control/DMA side and the network top's stream input.
- Honours backpressure even though the current consumer is always ready.

---
 rtl/axis_sample_feeder_pkg.sv | 15 +
 rtl/axis_sample_feeder_ram.sv | 39 +++
 rtl/axis_sample_feeder.sv | 224 ++++++++++++++++++++++
 tb/tb_axis_sample_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sample_feeder_pkg.sv
// Shared definitions for the sample feeder: FSM encoding and default sizing
// taken from the network's data width and layer-1 weight count.
package axis_sample_feeder_pkg;

  localparam int unsigned dataWidth       = 16;
  localparam int unsigned numWeightLayer1 = 784;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StSend  = 2'd2,
    StDone  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/axis_sample_feeder_ram.sv
// Simple dual-port sample buffer: one write port, one synchronous read port.
// Read-first on address collision. Only the read data register is reset.
module feeder_sample_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 784,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_sample_feeder.sv
// AXI-Stream master that replays one buffered input vector into the network.
// Optional macro FEEDER_DBUF_EN: ping-pong buffer, writes always go to the
// inactive bank, and a start in DONE launches the next vector immediately.
module axis_sample_feeder
  import axis_sample_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = dataWidth,
  parameter int unsigned NUM_SAMPLES = numWeightLayer1,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err,
  output logic [15:0]           vec_count
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_SAMPLES - 1);

`ifdef FEEDER_DBUF_EN
  localparam int unsigned RamDepth = 2 * NUM_SAMPLES;
  localparam int unsigned RamAw    = ADDR_WIDTH + 1;
`else
  localparam int unsigned RamDepth = NUM_SAMPLES;
  localparam int unsigned RamAw    = ADDR_WIDTH;
`endif

  feeder_state_e         state_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wr_err_q;
  logic [15:0]           vec_count_q;

  logic                  fire;
  logic                  addr_ok;
  logic                  start_take;
  logic                  wr_ok;
  logic                  wr_bad;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [RamAw-1:0]      ram_rd_addr;
  logic [RamAw-1:0]      ram_wr_addr;

`ifdef FEEDER_DBUF_EN
  logic send_bank_q;
  logic written_bank_q;
  logic new_bank;
  logic rd_bank;
`endif

  // Handshake, start acceptance and write filtering.
  always_comb begin
    fire    = valid_q && m_axis_ready;
    addr_ok = 32'(wr_addr) < NUM_SAMPLES;
`ifdef FEEDER_DBUF_EN
    start_take = start && ((state_q == StIdle) || (state_q == StDone));
    wr_ok      = wr_en && addr_ok;
    // A write in the start cycle lands in the inactive bank, so that bank is sent.
    new_bank   = wr_ok ? ~send_bank_q : written_bank_q;
`else
    start_take = start && (state_q == StIdle);
    wr_ok      = wr_en && addr_ok && (state_q == StIdle);
`endif
    wr_bad = wr_en && !wr_ok;
  end

  // Read address: address 0 on fetch, then prefetch the next word on each transfer.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = rd_ptr_q;
    unique case (state_q)
      StIdle: ;
      StFetch: begin
        rd_en  = 1'b1;
        rd_idx = '0;
      end
      StSend: begin
        rd_en = 1'b1;
        if (fire && (rd_ptr_q != LastIdx)) begin
          rd_idx = rd_ptr_q + ADDR_WIDTH'(1);
        end
      end
      StDone: begin
`ifdef FEEDER_DBUF_EN
        // Back-to-back start skips FETCH by reading word 0 here.
        if (start_take) begin
          rd_en  = 1'b1;
          rd_idx = '0;
        end
`endif
      end
    endcase
  end

  // Physical RAM addresses; bank 1 occupies the upper NUM_SAMPLES words.
  always_comb begin
`ifdef FEEDER_DBUF_EN
    rd_bank     = (state_q == StDone) ? new_bank : send_bank_q;
    ram_rd_addr = rd_bank ? RamAw'(rd_idx) + RamAw'(NUM_SAMPLES) : RamAw'(rd_idx);
    ram_wr_addr = send_bank_q ? RamAw'(wr_addr) : RamAw'(wr_addr) + RamAw'(NUM_SAMPLES);
`else
    ram_rd_addr = rd_idx;
    ram_wr_addr = wr_addr;
`endif
  end

`ifdef FEEDER_DBUF_EN
  // Bank bookkeeping: remember the bank last written and latch it on start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_bank_q    <= 1'b0;
      written_bank_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        written_bank_q <= ~send_bank_q;
      end
      if (start_take) begin
        send_bank_q <= new_bank;
      end
    end
  end
`endif

  // Transmit FSM with registered stream and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      vec_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      // A rejected write in the start cycle still gets reported.
      if (wr_bad) begin
        wr_err_q <= 1'b1;
      end else if (start_take) begin
        wr_err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start_take) begin
            state_q  <= StFetch;
            busy_q   <= 1'b1;
            rd_ptr_q <= '0;
          end
        end
        StFetch: begin
          state_q <= StSend;
          valid_q <= 1'b1;
          last_q  <= (NUM_SAMPLES == 1);
        end
        StSend: begin
          if (fire) begin
            if (rd_ptr_q == LastIdx) begin
              state_q     <= StDone;
              valid_q     <= 1'b0;
              last_q      <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              vec_count_q <= vec_count_q + 16'd1;
            end else begin
              rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
              last_q   <= ((rd_ptr_q + ADDR_WIDTH'(1)) == LastIdx);
            end
          end
        end
        StDone: begin
`ifdef FEEDER_DBUF_EN
          if (start_take) begin
            state_q  <= StSend;
            busy_q   <= 1'b1;
            rd_ptr_q <= '0;
            valid_q  <= 1'b1;
            last_q   <= (NUM_SAMPLES == 1);
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end
      endcase
    end
  end

  feeder_sample_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RamDepth),
    .ADDR_WIDTH (RamAw)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_ok),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (m_axis_data)
  );

  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wr_err       = wr_err_q;
  assign vec_count    = vec_count_q;

endmodule

// File: tb/tb_axis_sample_feeder.sv
// Directed bench for axis_sample_feeder with default sizing (784 x 16 bit).
module tb_axis_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic [15:0] m_axis_data;
  logic        m_axis_valid;
  logic        m_axis_ready;
  logic        m_axis_last;
  logic        busy;
  logic        done;
  logic        wr_err;
  logic [15:0] vec_count;

  int n_run  = 0;
  int n_fail = 0;
  int exp_vc = 0;

  always #5 clk = ~clk;

  axis_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .busy         (busy),
    .done         (done),
    .wr_err       (wr_err),
    .vec_count    (vec_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] cval, input bit use_const);
    for (int i = 0; i < 784; i++) begin
      wr_en   = 1'b1;
      wr_addr = 10'(i);
      wr_data = use_const ? cval : 16'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  // Start one vector and receive it under a 4-cycle ready pattern (bit c%4),
  // optionally injecting a write or a start pulse at a given cycle.
  task automatic run_vector(input string tag, input logic [3:0] rpat,
                            input int inj_wr_c, input logic [9:0] inj_addr,
                            input logic [15:0] inj_data, input int inj_start_c);
    int idx     = 0;
    int first_c = -1;
    int done_c  = -1;
    int c       = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_wr_err_start"}, 32'(wr_err), 32'd0);
    while (done_c < 0 && c < 8000) begin
      m_axis_ready = rpat[c % 4];
      wr_en        = (c == inj_wr_c);
      wr_addr      = inj_addr;
      wr_data      = inj_data;
      start        = (c == inj_start_c);
      if (m_axis_valid) begin
        if (first_c < 0) first_c = c;
        check({tag, "_data"}, 32'(m_axis_data), 32'(idx));
        check({tag, "_last"}, 32'(m_axis_last), (idx == 783) ? 32'd1 : 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (m_axis_ready) idx++;
      end
      if (done) begin
        done_c = c;
        exp_vc++;
        check({tag, "_vec_count"}, 32'(vec_count), 32'(exp_vc));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
      end
      step();
      c++;
    end
    wr_en        = 1'b0;
    start        = 1'b0;
    m_axis_ready = 1'b1;
    check({tag, "_first_valid_cycle"}, 32'(first_c), 32'd1);
    check({tag, "_beats"}, 32'(idx), 32'd784);
    if (rpat == 4'b1111) check({tag, "_done_cycle"}, 32'(done_c), 32'd785);
    check({tag, "_done_pulse_ends"}, 32'(done), 32'd0);
    check({tag, "_valid_after"}, 32'(m_axis_valid), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    start        = 1'b0;
    m_axis_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(m_axis_valid), 32'd0);
    check("rst_last", 32'(m_axis_last), 32'd0);
    check("rst_data", 32'(m_axis_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_vec_count", 32'(vec_count), 32'd0);
    rst = 1'b0;
    step();

    load(16'd0, 1'b0);
    check("load_wr_err", 32'(wr_err), 32'd0);

    // Full-rate vector, then ready 1,0,0,1 repeating.
    run_vector("t1", 4'b1111, -1, 10'd0, 16'd0, -1);
    run_vector("t2", 4'b1001, -1, 10'd0, 16'd0, -1);

`ifndef FEEDER_DBUF_EN
    // Write to addr 5 before beat 5 is read: dropped and flagged.
    run_vector("t3", 4'b1111, 3, 10'd5, 16'hAAAA, -1);
    check("t3_wr_err_sticky", 32'(wr_err), 32'd1);
`endif

    // Out-of-range write in IDLE, then a start pulse during SEND.
    wr_en   = 1'b1;
    wr_addr = 10'd800;
    wr_data = 16'h1234;
    step();
    wr_en = 1'b0;
    check("t4_wr_err_oob", 32'(wr_err), 32'd1);
    run_vector("t4", 4'b1111, -1, 10'd0, 16'd0, 100);
    step();
    step();
    check("t4_no_queued_start_valid", 32'(m_axis_valid), 32'd0);
    check("t4_no_queued_start_busy", 32'(busy), 32'd0);

    // Reset in the middle of a vector.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (300) step();
    check("t5_beat300", 32'(m_axis_data), 32'd300);
    check("t5_valid_pre", 32'(m_axis_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(m_axis_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_vec_count", 32'(vec_count), 32'd0);
    step();
    check("t5_rst_no_done", 32'(done), 32'd0);
    rst    = 1'b0;
    exp_vc = 0;
    step();
    check("t5_idle_no_done", 32'(done), 32'd0);
`ifdef FEEDER_DBUF_EN
    load(16'd0, 1'b0);
`endif
    run_vector("t5_resend", 4'b1111, -1, 10'd0, 16'd0, -1);

`ifdef FEEDER_DBUF_EN
    // Ping-pong: send 1s while writing 2s, then start again in DONE.
    load(16'd1, 1'b1);
    begin : dbuf_blk
      int  k;
      int  beats0;
      int  beats1;
      int  last0_c;
      int  first1_c;
      bit  fin;
      k        = 0;
      beats0   = 0;
      beats1   = 0;
      last0_c  = -1;
      first1_c = -1;
      fin      = 1'b0;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 4000 && !fin; c++) begin
        m_axis_ready = 1'b1;
        wr_en        = (c < 784);
        wr_addr      = 10'(c);
        wr_data      = 16'd2;
        start        = 1'b0;
        if (m_axis_valid) begin
          if (k == 0) begin
            check("dbuf_v0_data", 32'(m_axis_data), 32'd1);
            beats0++;
            last0_c = c;
          end else begin
            if (first1_c < 0) first1_c = c;
            check("dbuf_v1_data", 32'(m_axis_data), 32'd2);
            beats1++;
          end
        end
        if (done) begin
          exp_vc++;
          check("dbuf_vec_count", 32'(vec_count), 32'(exp_vc));
          if (k == 0) begin
            start = 1'b1;
            k     = 1;
          end else begin
            fin = 1'b1;
          end
        end
        step();
      end
      start = 1'b0;
      wr_en = 1'b0;
      check("dbuf_beats0", 32'(beats0), 32'd784);
      check("dbuf_beats1", 32'(beats1), 32'd784);
      check("dbuf_gap", 32'(first1_c - last0_c), 32'd2);
      check("dbuf_wr_err", 32'(wr_err), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
